// File: rtl/axi4l_arb_pkg.sv
// Shared types for the AXI4-Lite round-robin master arbiter: FSM states and response codes.
package axi4l_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first requester at or after ptr wins (one-hot + index).
module rr_grant #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             req_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    req_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((32'(ptr) + 32'(i)) % 32'(NREQ));
      if (!req_any && req[cand]) begin
        req_any      = 1'b1;
        gnt_idx      = cand;
        gnt[cand]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4l_rr_master_arbiter.sv
// Round-robin arbiter turning client req/ack transfers into single AXI4-Lite transactions.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module axi4l_rr_master_arbiter
  import axi4l_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*32-1:0]     wdata,
  input  logic [NREQ*4-1:0]      wstrb,
  output logic [NREQ-1:0]        ack,
  output logic [31:0]            rdata,
  output logic                   err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [2:0]             awprot,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [31:0]            wdata_m,
  output logic [3:0]             wstrb_m,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_W-1:0]      araddr,
  output logic [2:0]             arprot,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [31:0]            rdata_m,
  input  logic [1:0]             rresp
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] ptr, win_idx;
  logic [NREQ-1:0]  win_oh, gnt_oh;
  logic             req_any;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]      l_wdata;
  logic [3:0]       l_wstrb;
  logic             aw_done, w_done, aw_fin, w_fin, timeout_hit;

  rr_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_grant (
    .req     (req),
    .ptr     (ptr),
    .gnt     (win_oh),
    .gnt_idx (win_idx),
    .req_any (req_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wd_cnt;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)                           wd_cnt <= '0;
    else if (state == IDLE || state == DONE) wd_cnt <= '0;
    else                                     wd_cnt <= wd_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th busy cycle so DONE lands exactly TIMEOUT cycles after leaving IDLE.
  assign timeout_hit = (state inside {WR_ADDR, WR_RESP, RD_ADDR, RD_RESP}) &&
                       (wd_cnt == TO_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  assign aw_fin  = aw_done | (awvalid & awready);
  assign w_fin   = w_done  | (wvalid  & wready);

  assign awaddr  = l_addr;
  assign araddr  = l_addr;
  assign wdata_m = l_wdata;
  assign wstrb_m = l_wstrb;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;

  always_comb begin
    state_nxt = state;
    bready    = 1'b0;
    rready    = 1'b0;
    ack       = '0;
    case (state)
      IDLE:    if (req_any) state_nxt = we[win_idx] ? WR_ADDR : RD_ADDR;
      WR_ADDR: if (aw_fin && w_fin) state_nxt = WR_RESP;
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      RD_ADDR: if (arvalid && arready) state_nxt = RD_RESP;
      RD_RESP: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      DONE: begin
        ack       = gnt_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = DONE;
      bready    = 1'b0;
      rready    = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_oh  <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_wstrb <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (req_any) begin
            gnt_oh  <= win_oh;
            l_addr  <= addr[win_idx*ADDR_W +: ADDR_W];
            l_wdata <= wdata[win_idx*32 +: 32];
            l_wstrb <= wstrb[win_idx*4 +: 4];
            ptr     <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
          end
        end
        // Each channel raises once and drops after its own handshake; order is free.
        WR_ADDR: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end else if (!aw_done) begin
            awvalid <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end else if (!w_done) begin
            wvalid <= 1'b1;
          end
        end
        WR_RESP: if (bvalid) begin
          err   <= resp_is_err(bresp);
          rdata <= '0;
        end
        RD_ADDR: arvalid <= !(arvalid && arready);
        RD_RESP: if (rvalid) begin
          err   <= resp_is_err(rresp);
          rdata <= rdata_m;
        end
        default: ;
      endcase
      if (timeout_hit) begin
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        arvalid <= 1'b0;
        err     <= 1'b1;
        rdata   <= '0;
      end
    end
  end

endmodule
